// File: rtl/rv32i_pkg.sv
// rv32i shared types: memory arbiter states, owners and request bundle.
// Used by mem_arbiter (optional perf counters: MEM_ARB_PERF_EN).
package rv32i_pkg;

  localparam int ARB_AW = 16;
  localparam int ARB_DW = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_e;

  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Fixed D > I winner select with a starvation counter that forces I.
// Counter only moves while the arbiter is idle (en_i).
module arb_prio_sel
  import rv32i_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic sel_i_o,
  output logic sel_d_o
);

  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    sel_i_o = 1'b0;
    sel_d_o = 1'b0;
    unique case (1'b1)
      i_req_i && !d_req_i: sel_i_o = 1'b1;
      !i_req_i && d_req_i: sel_d_o = 1'b1;
      i_req_i && d_req_i: begin
        sel_i_o = starved;
        sel_d_o = !starved;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_cnt <= '0;
    end else if (en_i) begin
      if (sel_i_o || !i_req_i) begin
        starve_cnt <= '0;
      end else if (sel_d_o && starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch (I) and load/store (D) ports.
// Define MEM_ARB_PERF_EN to add grant/stall performance counters.
module mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int AW           = ARB_AW,
  parameter int DW           = ARB_DW,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          i_req_i,
  input  logic [AW-1:0] i_addr_i,
  output logic          i_gnt_o,
  output logic          i_rvalid_o,
  output logic [DW-1:0] i_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [3:0]    d_be_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_i_cnt_o,
  output logic [31:0]   perf_d_cnt_o,
  output logic [31:0]   perf_stall_cnt_o
`endif
);

  arb_state_e state;
  arb_owner_e owner;
  mem_req_t   mreq;
  logic       idle;
  logic       sel_i;
  logic       sel_d;

  assign idle = (state == IDLE);

  arb_prio_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (idle),
    .i_req_i(i_req_i),
    .d_req_i(d_req_i),
    .sel_i_o(sel_i),
    .sel_d_o(sel_d)
  );

  assign i_gnt_o     = idle & sel_i;
  assign d_gnt_o     = idle & sel_d;
  assign mem_we_o    = mreq.we;
  assign mem_be_o    = mreq.be;
  assign mem_addr_o  = mreq.addr;
  assign mem_wdata_o = mreq.wdata;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      owner      <= OWN_I;
      mreq       <= '0;
      mem_req_o  <= 1'b0;
      i_rvalid_o <= 1'b0;
      d_rvalid_o <= 1'b0;
      i_rdata_o  <= '0;
      d_rdata_o  <= '0;
    end else begin
      i_rvalid_o <= 1'b0;
      d_rvalid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (d_gnt_o) begin
            state      <= REQ;
            mem_req_o  <= 1'b1;
            owner      <= OWN_D;
            mreq.we    <= d_we_i;
            mreq.be    <= d_be_i;
            mreq.addr  <= d_addr_i;
            mreq.wdata <= d_wdata_i;
          end else if (i_gnt_o) begin
            state      <= REQ;
            mem_req_o  <= 1'b1;
            owner      <= OWN_I;
            mreq.we    <= 1'b0;
            mreq.be    <= 4'hF;
            mreq.addr  <= i_addr_i;
            mreq.wdata <= '0;
          end
        end
        REQ: begin
          // a same-cycle rvalid is a protocol error and is dropped
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid_i) begin
            state <= IDLE;
            if (owner == OWN_D) begin
              d_rvalid_o <= 1'b1;
              d_rdata_o  <= mem_rdata_i;
            end else begin
              i_rvalid_o <= 1'b1;
              i_rdata_o  <= mem_rdata_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic stall;

  assign stall = (i_req_i & ~i_gnt_o) | (d_req_i & ~d_gnt_o);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_i_cnt_o     <= '0;
      perf_d_cnt_o     <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      perf_i_cnt_o     <= perf_i_cnt_o + 32'(i_gnt_o);
      perf_d_cnt_o     <= perf_d_cnt_o + 32'(d_gnt_o);
      perf_stall_cnt_o <= perf_stall_cnt_o + 32'(stall);
    end
  end
`endif

  a_rvalid_in_resp: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    mem_rvalid_i |-> state == RESP
  );

  a_no_gnt_rvalid: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    !(state == REQ && mem_gnt_i && mem_rvalid_i)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model.
// Build with MEM_ARB_PERF_EN to also check the perf counters.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_i;
  logic [31:0]   perf_d;
  logic [31:0]   perf_stall;
`endif

  mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .i_req_i     (i_req),
    .i_addr_i    (i_addr),
    .i_gnt_o     (i_gnt),
    .i_rvalid_o  (i_rvalid),
    .i_rdata_o   (i_rdata),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_be_i      (d_be),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_gnt_o     (d_gnt),
    .d_rvalid_o  (d_rvalid),
    .d_rdata_o   (d_rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_gnt_i   (mem_gnt),
    .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_i_cnt_o    (perf_i),
    .perf_d_cnt_o    (perf_d),
    .perf_stall_cnt_o(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // transaction-level model: one outstanding access at most
  bit            busy;
  bit            acc;
  bit            own_d;
  logic          rec_we;
  logic [3:0]    rec_be;
  logic [AW-1:0] rec_addr;
  logic [DW-1:0] rec_wd;
  int            starve;
  int            resp_port;
  logic [DW-1:0] resp_data;
  bit            exp_ig;
  bit            exp_dg;
  int            n_ig;
  int            n_dg;
  int            n_stall;

  bit mem_rnd;
  bit mem_hold;
  bit rnd_req;
  bit keep_d;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 0; acc = 0; own_d = 0; starve = 0; resp_port = 0;
    n_ig = 0; n_dg = 0; n_stall = 0;
  endtask

  task automatic model_step();
    bit was_busy;
    was_busy  = busy;
    resp_port = 0;
    if (busy && acc && mem_rvalid) begin
      resp_port = own_d ? 2 : 1;
      resp_data = mem_rdata;
      busy      = 0;
    end else if (busy && !acc && mem_gnt) begin
      acc = 1;
    end
    if ((i_req && !exp_ig) || (d_req && !exp_dg)) n_stall++;
    if (!was_busy) begin
      if (exp_dg) begin
        busy = 1; acc = 0; own_d = 1; n_dg++;
        rec_we = d_we; rec_be = d_be;
        rec_addr = d_addr; rec_wd = d_wdata;
      end else if (exp_ig) begin
        busy = 1; acc = 0; own_d = 0; n_ig++;
        rec_we = 0; rec_be = 4'hF;
        rec_addr = i_addr; rec_wd = '0;
      end
      if (exp_ig || !i_req) starve = 0;
      else if (exp_dg && starve < 15) starve++;
    end
  endtask

  task automatic drive_mem();
    mem_gnt    = 0;
    mem_rvalid = 0;
    mem_rdata  = 32'($urandom);
    if (busy && !acc && !mem_hold)
      mem_gnt = !mem_rnd || ($urandom_range(0, 2) == 0);
    if (busy && acc)
      mem_rvalid = !mem_rnd || ($urandom_range(0, 1) == 0);
  endtask

  task automatic drive_req();
    if (rnd_req) begin
      if (!(i_req && !exp_ig && $urandom_range(0, 15) != 0)) begin
        i_req  = ($urandom_range(0, 2) == 0);
        i_addr = 16'($urandom);
      end
      if (!(d_req && !exp_dg && $urandom_range(0, 15) != 0)) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_we    = 1'($urandom);
        d_be    = 4'($urandom);
        d_addr  = 16'($urandom);
        d_wdata = 32'($urandom);
      end
    end else begin
      if (exp_ig) i_req = 0;
      if (exp_dg && !keep_d) d_req = 0;
    end
  endtask

  // one clock: check outputs, advance model, drive next inputs
  task automatic tick();
    #1;
    exp_ig = 0;
    exp_dg = 0;
    if (!busy) begin
      if (i_req && d_req) begin
        exp_ig = (starve == LIM);
        exp_dg = !exp_ig;
      end else begin
        exp_ig = i_req;
        exp_dg = d_req;
      end
    end
    chk("i_gnt", 64'(i_gnt), 64'(exp_ig));
    chk("d_gnt", 64'(d_gnt), 64'(exp_dg));
    chk("mem_req", 64'(mem_req), 64'(busy && !acc));
    if (busy && !acc) begin
      chk("mem_we", 64'(mem_we), 64'(rec_we));
      chk("mem_be", 64'(mem_be), 64'(rec_be));
      chk("mem_addr", 64'(mem_addr), 64'(rec_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(rec_wd));
    end
    chk("i_rvalid", 64'(i_rvalid), 64'(resp_port == 1));
    chk("d_rvalid", 64'(d_rvalid), 64'(resp_port == 2));
    if (resp_port == 1) chk("i_rdata", 64'(i_rdata), 64'(resp_data));
    if (resp_port == 2) chk("d_rdata", 64'(d_rdata), 64'(resp_data));
    model_step();
    @(negedge clk);
    drive_req();
    drive_mem();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (busy || i_req || d_req); k++) tick();
    chk("drain", 64'(busy || i_req || d_req), 64'(0));
    tick();
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_i_gnt"}, 64'(i_gnt), 64'(0));
    chk({nm, "_i_rvalid"}, 64'(i_rvalid), 64'(0));
    chk({nm, "_i_rdata"}, 64'(i_rdata), 64'(0));
    chk({nm, "_d_gnt"}, 64'(d_gnt), 64'(0));
    chk({nm, "_d_rvalid"}, 64'(d_rvalid), 64'(0));
    chk({nm, "_d_rdata"}, 64'(d_rdata), 64'(0));
    chk({nm, "_mem_req"}, 64'(mem_req), 64'(0));
    chk({nm, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({nm, "_mem_be"}, 64'(mem_be), 64'(0));
    chk({nm, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({nm, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
  endtask

  task automatic starve_round(input string nm);
    int dn;
    bit got_i;
    dn = 0;
    got_i = 0;
    i_req = 1; i_addr = 16'h0040;
    d_req = 1; d_we = 0; d_be = 4'hF;
    d_addr = 16'h0300; d_wdata = '0;
    drive_mem();
    for (int k = 0; k < 80 && !got_i; k++) begin
      #1;
      if (d_gnt) dn++;
      if (i_gnt) got_i = 1;
      tick();
    end
    chk({nm, "_i_granted"}, 64'(got_i), 64'(1));
    chk({nm, "_d_grants"}, 64'(dn), 64'(LIM));
  endtask

  initial begin
    rstn = 0;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    mem_rnd = 0; mem_hold = 0; rnd_req = 0; keep_d = 0;
    model_reset();
    exp_ig = 0; exp_dg = 0;
    resp_data = '0;
    rec_we = 0; rec_be = '0; rec_addr = '0; rec_wd = '0;
    repeat (2) @(negedge clk);
    #1 all_zero("reset");
    @(negedge clk);
    rstn = 1;

    // single fetch, zero-wait memory
    i_req = 1; i_addr = 16'h0004;
    #1 chk("t1_gnt_c0", 64'(i_gnt), 64'(1));
    tick();
    #1 chk("t1_mreq_c1", 64'(mem_req), 64'(1));
    chk("t1_addr_c1", 64'(mem_addr), 64'(16'h0004));
    tick();
    mem_rdata = 32'h00500093;
    tick();
    #1 chk("t1_rvalid_c3", 64'(i_rvalid), 64'(1));
    chk("t1_rdata_c3", 64'(i_rdata), 64'(32'h00500093));
    tick();
    drain();

    // simultaneous requests: D store first, then I
    i_req = 1; i_addr = 16'h0008;
    d_req = 1; d_we = 1; d_be = 4'hF;
    d_addr = 16'h0100; d_wdata = 32'hDEADBEEF;
    #1 chk("t2_d_gnt", 64'(d_gnt), 64'(1));
    chk("t2_i_nogn", 64'(i_gnt), 64'(0));
    tick();
    #1 chk("t2_we", 64'(mem_we), 64'(1));
    chk("t2_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
    chk("t2_addr", 64'(mem_addr), 64'(16'h0100));
    tick();
    tick();
    #1 chk("t2_i_gnt", 64'(i_gnt), 64'(1));
    tick();
    drain();

    // starvation guard: two rounds prove the counter restarts at 0
    keep_d = 1;
    starve_round("starve1");
    starve_round("starve2");
    keep_d = 0;
    d_req = 0;
    i_req = 0;
    drain();

    // memory withholds gnt for 5 cycles
    mem_hold = 1;
    d_req = 1; d_we = 0; d_be = 4'h3;
    d_addr = 16'h0200; d_wdata = 32'h12345678;
    tick();
    i_req = 1; i_addr = 16'h0010;
    for (int k = 0; k < 5; k++) begin
      #1 chk("hold_mreq", 64'(mem_req), 64'(1));
      chk("hold_addr", 64'(mem_addr), 64'(16'h0200));
      chk("hold_be", 64'(mem_be), 64'(4'h3));
      chk("hold_no_gnt", 64'(i_gnt || d_gnt), 64'(0));
      tick();
    end
    mem_hold = 0;
    drive_mem();
    drain();

    // reset while waiting for the response
    d_req = 1; d_we = 0; d_be = 4'hF;
    d_addr = 16'h0020; d_wdata = '0;
    tick();
    tick();
    chk("rst_in_resp", 64'(busy && acc), 64'(1));
    rstn = 0;
    i_req = 0; d_req = 0; mem_gnt = 0; mem_rvalid = 0;
    #1 all_zero("midrst");
    model_reset();
    @(negedge clk);
    mem_rvalid = 1;
    @(negedge clk);
    mem_rvalid = 0;
    rstn = 1;
    repeat (3) tick();

    // randomized traffic and memory latency
    mem_rnd = 1;
    rnd_req = 1;
    repeat (3000) tick();
    rnd_req = 0;
    i_req = 0;
    d_req = 0;
    drain();

`ifdef MEM_ARB_PERF_EN
    #1 chk("perf_i", 64'(perf_i), 64'(n_ig));
    chk("perf_d", 64'(perf_d), 64'(n_dg));
    chk("perf_stall", 64'(perf_stall), 64'(n_stall));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
